// File: rtl/secp256k1_pkg.sv
// rtl/secp256k1_pkg.sv - secp256k1 field constants, op codes and scheduler state encoding
package secp256k1_pkg;

  localparam int W = 256;
  localparam logic [W-1:0] P =
    256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F;

  localparam logic OP_SUB = 1'b0;
  localparam logic OP_ADD = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_NEG  = 2'd1,
    ST_EXEC = 2'd2,
    ST_RESP = 2'd3
  } state_e;

endpackage

// File: rtl/mod_sub.sv
// rtl/mod_sub.sv - combinational (x - y) mod P for operands already reduced below P
module mod_sub
  import secp256k1_pkg::*;
(
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  output logic [W-1:0] d
);

  logic [W:0]   diff;
  logic [W-1:0] wrapped;

  // A borrow means x < y, so folding P back in lands the result in 0..P-1.
  assign diff    = {1'b0, x} - {1'b0, y};
  assign wrapped = diff[W-1:0] + P;
  assign d       = diff[W] ? wrapped : diff[W-1:0];

endmodule

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick starting at ptr, wrapping at NUM_REQ
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [ID_W-1:0]    idx,
  output logic               any_req
);

  logic found;
  int   j;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    j     = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = int'(ptr) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (!found && req[j]) begin
        found  = 1'b1;
        gnt[j] = 1'b1;
        idx    = ID_W'(j);
      end
    end
  end

  assign any_req = |req;

endmodule

// File: rtl/modsub_sched.sv
// rtl/modsub_sched.sv - round-robin scheduler sharing one secp256k1 mod_sub among requesters
// MODSUB_ADD_EN: req_op=1 computes (x + y) mod P as x - (P - y) via an extra NEG pass.
module modsub_sched #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2,
  parameter int W       = 256
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req_valid,
  output logic [NUM_REQ-1:0]   req_ready,
  input  logic [NUM_REQ*W-1:0] req_x,
  input  logic [NUM_REQ*W-1:0] req_y,
  input  logic [NUM_REQ-1:0]   req_op,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic [ID_W-1:0]      resp_id,
  output logic [W-1:0]         resp_data,
  output logic                 busy
);
  import secp256k1_pkg::*;

  state_e            state_q, state_d;
  logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]   id_q, id_d;
  logic [W-1:0]      x_q, x_d;
  logic [W-1:0]      y_q, y_d;
  logic [W-1:0]      res_q, res_d;
  logic [W-1:0]      sub_a, sub_b, sub_out;
  logic [NUM_REQ-1:0] gnt;
  logic [ID_W-1:0]   gnt_idx;
  logic              any_req;

  rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_arb (
    .req     (req_valid),
    .ptr     (rr_ptr_q),
    .gnt     (gnt),
    .idx     (gnt_idx),
    .any_req (any_req)
  );

  mod_sub u_sub (
    .x (sub_a),
    .y (sub_b),
    .d (sub_out)
  );

`ifdef MODSUB_ADD_EN
  // NEG reuses the subtractor as 0 - y to turn an add into a subtract.
  assign sub_a = (state_q == ST_NEG) ? '0 : x_q;
`else
  logic unused_op;
  assign unused_op = ^req_op;
  assign sub_a     = x_q;
`endif
  assign sub_b = y_q;

  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    id_d      = id_q;
    x_d       = x_q;
    y_d       = y_q;
    res_d     = res_q;
    req_ready = '0;
    case (state_q)
      ST_IDLE: begin
        if (any_req) begin
          req_ready = reset ? '0 : gnt;
          x_d       = req_x[gnt_idx*W +: W];
          y_d       = req_y[gnt_idx*W +: W];
          id_d      = gnt_idx;
`ifdef MODSUB_ADD_EN
          state_d   = (req_op[gnt_idx] == OP_ADD) ? ST_NEG : ST_EXEC;
`else
          state_d   = ST_EXEC;
`endif
        end
      end
`ifdef MODSUB_ADD_EN
      ST_NEG: begin
        y_d     = sub_out;
        state_d = ST_EXEC;
      end
`endif
      ST_EXEC: begin
        res_d   = sub_out;
        state_d = ST_RESP;
      end
      ST_RESP: begin
        if (resp_ready) begin
          state_d  = ST_IDLE;
          rr_ptr_d = (id_q == ID_W'(NUM_REQ - 1)) ? '0 : id_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      rr_ptr_q <= '0;
      id_q     <= '0;
      x_q      <= '0;
      y_q      <= '0;
      res_q    <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      id_q     <= id_d;
      x_q      <= x_d;
      y_q      <= y_d;
      res_q    <= res_d;
    end
  end

  assign resp_valid = (state_q == ST_RESP);
  assign resp_id    = id_q;
  assign resp_data  = res_q;
  assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_modsub_sched.sv
// tb/tb_modsub_sched.sv - directed self-checking bench for modsub_sched
module tb_modsub_sched;
  import secp256k1_pkg::*;

  localparam int N   = 4;
  localparam int IDW = 2;

  logic             clk;
  logic             reset;
  logic [N-1:0]     req_valid;
  logic [N-1:0]     req_ready;
  logic [N*256-1:0] req_x;
  logic [N*256-1:0] req_y;
  logic [N-1:0]     req_op;
  logic             resp_valid;
  logic             resp_ready;
  logic [IDW-1:0]   resp_id;
  logic [255:0]     resp_data;
  logic             busy;

  int cyc;
  int n_vec;
  int n_err;

  modsub_sched #(.NUM_REQ(N), .ID_W(IDW), .W(256)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_x      (req_x),
    .req_y      (req_y),
    .req_op     (req_op),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_id    (resp_id),
    .resp_data  (resp_data),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input int i, input logic [255:0] x, input logic [255:0] y,
                       input logic op, output int t_hs);
    bit done;
    done = 1'b0;
    t_hs = -1;
    req_x[i*256 +: 256] = x;
    req_y[i*256 +: 256] = y;
    req_op[i]    = op;
    req_valid[i] = 1'b1;
    for (int k = 0; k < 40 && !done; k++) begin
      #1;
      if (req_ready[i]) begin
        t_hs = cyc;
        done = 1'b1;
      end
      step();
    end
    if (!done) check_eq("grant_timeout", {255'd0, req_ready[i]}, 256'd1);
    req_valid[i] = 1'b0;
  endtask

  task automatic wait_resp(output int t_rv);
    bit done;
    done = 1'b0;
    t_rv = -1;
    for (int k = 0; k < 40 && !done; k++) begin
      #1;
      if (resp_valid) begin
        t_rv = cyc;
        done = 1'b1;
      end else begin
        step();
      end
    end
    if (!done) check_eq("resp_timeout", {255'd0, resp_valid}, 256'd1);
  endtask

  task automatic run_op(input string tag, input int i, input logic [255:0] x,
                        input logic [255:0] y, input logic op,
                        input logic [255:0] exp, input int exp_lat);
    int t_hs, t_rv;
    issue(i, x, y, op, t_hs);
    wait_resp(t_rv);
    check_eq({tag, "_id"}, {254'd0, resp_id}, i);
    check_eq({tag, "_data"}, resp_data, exp);
    check_eq({tag, "_lat"}, t_rv - t_hs, exp_lat);
    step();
  endtask

  task automatic rr_round(input string tag, input int ord0, input int ord1,
                          input int ord2, input int ord3);
    int ord[4];
    int t_rv;
    ord = '{ord0, ord1, ord2, ord3};
    for (int i = 0; i < N; i++) begin
      req_x[i*256 +: 256] = 256'd10;
      req_y[i*256 +: 256] = 256'(i + 1);
      req_op[i] = OP_SUB;
    end
    req_valid = '1;
    for (int r = 0; r < N; r++) begin
      wait_resp(t_rv);
      check_eq($sformatf("%s_id%0d", tag, r), {254'd0, resp_id}, ord[r]);
      check_eq($sformatf("%s_data%0d", tag, r), resp_data, 256'(9 - ord[r]));
      req_valid[resp_id] = 1'b0;
      step();
    end
    req_valid = '0;
  endtask

  initial begin
    int t_hs, t_rv;
    n_vec      = 0;
    n_err      = 0;
    reset      = 1'b1;
    req_valid  = '0;
    req_x      = '0;
    req_y      = '0;
    req_op     = '0;
    resp_ready = 1'b1;
    step();
    step();
    check_eq("rst_busy", {255'd0, busy}, 256'd0);
    check_eq("rst_resp_valid", {255'd0, resp_valid}, 256'd0);
    check_eq("rst_resp_id", {254'd0, resp_id}, 256'd0);
    check_eq("rst_resp_data", resp_data, 256'd0);
    req_valid[0] = 1'b1;
    #1;
    check_eq("rst_req_ready", {252'd0, req_ready}, 256'd0);
    req_valid = '0;
    step();
    reset = 1'b0;

    // basic subtraction vectors, including wrap and range edges
    run_op("sub_5_3", 0, 256'd5, 256'd3, OP_SUB, 256'd2, 2);
    run_op("sub_3_5", 2, 256'd3, 256'd5, OP_SUB, P - 256'd2, 2);
    run_op("sub_0_pm1", 1, 256'd0, P - 256'd1, OP_SUB, 256'd1, 2);
    run_op("sub_eq", 3, P - 256'd1, P - 256'd1, OP_SUB, 256'd0, 2);
    run_op("sub_pm1_0", 0, P - 256'd1, 256'd0, OP_SUB, P - 256'd1, 2);

    // all requesters together straight out of reset, then from rr_ptr=2
    reset = 1'b1;
    step();
    for (int i = 0; i < N; i++) begin
      req_x[i*256 +: 256] = 256'd10;
      req_y[i*256 +: 256] = 256'(i + 1);
    end
    req_valid = '1;
    step();
    reset = 1'b0;
    rr_round("rr1", 0, 1, 2, 3);
    run_op("rr_prime", 1, 256'd20, 256'd7, OP_SUB, 256'd13, 2);
    rr_round("rr2", 2, 3, 0, 1);

    // consumer back-pressure
    resp_ready = 1'b0;
    issue(3, 256'd100, 256'd1, OP_SUB, t_hs);
    req_x[0 +: 256] = 256'd50;
    req_y[0 +: 256] = 256'd1;
    req_valid[0] = 1'b1;
    wait_resp(t_rv);
    for (int k = 0; k < 10; k++) begin
      step();
      #1;
      check_eq($sformatf("hold_valid%0d", k), {255'd0, resp_valid}, 256'd1);
      check_eq($sformatf("hold_id%0d", k), {254'd0, resp_id}, 256'd3);
      check_eq($sformatf("hold_data%0d", k), resp_data, 256'd99);
      check_eq($sformatf("hold_ready%0d", k), {252'd0, req_ready}, 256'd0);
    end
    req_valid[0] = 1'b0;
    resp_ready = 1'b1;
    step();
    #1;
    check_eq("rel_resp_valid", {255'd0, resp_valid}, 256'd0);
    check_eq("rel_busy", {255'd0, busy}, 256'd0);
    check_eq("rel_data_kept", resp_data, 256'd99);

    // reset while an operation is in EXEC
    issue(0, 256'd9, 256'd4, OP_SUB, t_hs);
    req_x[256 +: 256] = 256'd20;
    req_y[256 +: 256] = 256'd7;
    req_valid[1] = 1'b1;
    reset = 1'b1;
    #1;
    check_eq("mid_busy", {255'd0, busy}, 256'd0);
    check_eq("mid_resp_valid", {255'd0, resp_valid}, 256'd0);
    check_eq("mid_resp_id", {254'd0, resp_id}, 256'd0);
    check_eq("mid_resp_data", resp_data, 256'd0);
    check_eq("mid_req_ready", {252'd0, req_ready}, 256'd0);
    step();
    reset = 1'b0;
    req_valid[1] = 1'b0;
    run_op("post_rst", 1, 256'd20, 256'd7, OP_SUB, 256'd13, 2);

    // add requests: two-pass when enabled, plain subtract otherwise
`ifdef MODSUB_ADD_EN
    run_op("add_pm1_2", 0, P - 256'd1, 256'd2, OP_ADD, 256'd1, 3);
    run_op("add_0_0", 2, 256'd0, 256'd0, OP_ADD, 256'd0, 3);
`else
    run_op("add_pm1_2", 0, P - 256'd1, 256'd2, OP_ADD, P - 256'd3, 2);
    run_op("add_0_0", 2, 256'd0, 256'd0, OP_ADD, 256'd0, 2);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
